rom_ddram_bridge: RTL and testbench

// - Responder end of the core's toggle req/ack ROM interface, terminating it on the HPS DDRAM Avalon master.
// - Write side takes 16-bit ROM download words. Read side returns 64-bit words to the Genesis cartridge fetch.
// - One-entry read cache hides DDRAM latency on repeated fetches of the same 64-bit word.

---
 rtl/rom_ddram_bridge_if.sv | 36 +++
 rtl/rom_ddram_bridge.sv | 105 ++++++++++
 tb/tb_rom_ddram_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_ddram_bridge_if.sv
// ROM toggle req/ack port plus the HPS DDRAM Avalon master signals.
// The bridge takes the slave view; the core/memory environment takes the master view.
interface rom_ddram_bridge_if;
    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [24:0] rdaddr;
    logic [63:0] dout;
    logic        rd_req;
    logic        rd_ack;

    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport slave (
        input  wraddr, din, we_req, rdaddr, rd_req,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output we_ack, dout, rd_ack,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport master (
        output wraddr, din, we_req, rdaddr, rd_req,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  we_ack, dout, rd_ack,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );
endinterface

// File: rtl/rom_ddram_bridge.sv
// Toggle req/ack ROM responder terminating on the DDRAM Avalon master, with a
// one-entry 64-bit read cache in front of DDRAM read latency.
module rom_ddram_bridge #(
    parameter logic [6:0] BASE = 7'h18
) (
    input logic                clk_sys,
    input logic                reset,
    rom_ddram_bridge_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, WR, RD, RDWAIT} state_t;

    state_t      state;
    logic [21:0] cache_addr;
    logic [63:0] cache_data;
    logic        cache_valid;
    logic        discard;

    logic wr_pend;
    logic rd_pend;
    logic rd_hit;
    logic unused_addr_bits;

    assign wr_pend = bus.we_req != bus.we_ack;
    assign rd_pend = bus.rd_req != bus.rd_ack;
    assign rd_hit  = cache_valid && (cache_addr == bus.rdaddr[24:3]);

    assign bus.DDRAM_BURSTCNT = 8'd1;
    assign unused_addr_bits   = ^{bus.wraddr[0], bus.rdaddr[2:0]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bus.we_ack     <= bus.we_req;
            bus.rd_ack     <= bus.rd_req;
            bus.DDRAM_RD   <= 1'b0;
            bus.DDRAM_WE   <= 1'b0;
            bus.DDRAM_ADDR <= '0;
            bus.DDRAM_DIN  <= '0;
            bus.DDRAM_BE   <= '0;
            bus.dout       <= '0;
            cache_valid    <= 1'b0;
            state          <= IDLE;
            // A read already accepted by DDRAM will still return one beat; swallow it.
            if (state == RDWAIT && !bus.DDRAM_DOUT_READY)
                discard <= 1'b1;
            else if (bus.DDRAM_DOUT_READY)
                discard <= 1'b0;
        end else begin
            if (discard && bus.DDRAM_DOUT_READY)
                discard <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_pend) begin
                        bus.DDRAM_ADDR <= {BASE, bus.wraddr[24:3]};
                        bus.DDRAM_DIN  <= {4{bus.din}};
                        bus.DDRAM_BE   <= 8'b11 << {bus.wraddr[2:1], 1'b0};
                        bus.DDRAM_WE   <= 1'b1;
                        state          <= WR;
                        if (cache_addr == bus.wraddr[24:3])
                            cache_valid <= 1'b0;
                    end else if (rd_pend) begin
                        if (rd_hit) begin
                            bus.dout   <= cache_data;
                            bus.rd_ack <= bus.rd_req;
                        end else if (!discard) begin
                            bus.DDRAM_ADDR <= {BASE, bus.rdaddr[24:3]};
                            bus.DDRAM_RD   <= 1'b1;
                            state          <= RD;
                        end
                    end
                end

                WR: begin
                    if (!bus.DDRAM_BUSY) begin
                        bus.DDRAM_WE <= 1'b0;
                        bus.we_ack   <= bus.we_req;
                        state        <= IDLE;
                    end
                end

                RD: begin
                    if (!bus.DDRAM_BUSY) begin
                        bus.DDRAM_RD <= 1'b0;
                        state        <= RDWAIT;
                    end
                end

                RDWAIT: begin
                    if (bus.DDRAM_DOUT_READY) begin
                        bus.dout    <= bus.DDRAM_DOUT;
                        cache_data  <= bus.DDRAM_DOUT;
                        cache_addr  <= bus.DDRAM_ADDR[21:0];
                        cache_valid <= 1'b1;
                        bus.rd_ack  <= bus.rd_req;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_ddram_bridge.sv
// Scoreboard bench for rom_ddram_bridge: halfword-granular reference memory and
// cache model feed expectation queues; a monitor pops them as the DUT responds.
module tb_rom_ddram_bridge;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    rom_ddram_bridge_if bus();

    rom_ddram_bridge #(.BASE(7'h18)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    localparam logic [6:0] BASE = 7'h18;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] data;
        bit          miss;
    } rd_exp_t;

    typedef struct {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_cmd_t;

    rd_exp_t     rd_q[$];
    wr_cmd_t     wcmd_q[$];
    logic [28:0] rdcmd_q[$];
    int          wr_ack_pending = 0;

    logic [15:0] ref_half [logic [23:0]];
    logic [63:0] mem64    [logic [21:0]];
    bit          cache_v = 0;
    logic [21:0] cache_w = '0;

    int lat_fixed   = -1;
    bit rand_busy   = 0;
    int busy_hold   = 0;
    int rd_accepts  = 0;
    int we_busy_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_half(input logic [23:0] h);
        return h[15:0] ^ {h[23:16], h[7:0]} ^ 16'h5A3C;
    endfunction

    function automatic logic [63:0] ref_word(input logic [21:0] w);
        logic [63:0] r;
        logic [23:0] h;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            h = {w, 2'(k)};
            r[16*k +: 16] = ref_half.exists(h) ? ref_half[h] : init_half(h);
        end
        return r;
    endfunction

    function automatic logic [63:0] slave_read(input logic [21:0] w);
        if (mem64.exists(w)) return mem64[w];
        return {init_half({w, 2'd3}), init_half({w, 2'd2}), init_half({w, 2'd1}), init_half({w, 2'd0})};
    endfunction

    task automatic preload(input logic [21:0] w, input logic [63:0] d);
        mem64[w] = d;
        for (int k = 0; k < 4; k++) ref_half[{w, 2'(k)}] = d[16*k +: 16];
    endtask

    // DDRAM Avalon responder
    bit          s_acc_wr, s_acc_rd, rd_active;
    logic [28:0] s_a;
    logic [63:0] s_d, s_word;
    logic [7:0]  s_be;
    logic [21:0] rd_w;
    int          rd_cnt;
    initial begin
        bus.DDRAM_BUSY = 1'b0;
        bus.DDRAM_DOUT_READY = 1'b0;
        bus.DDRAM_DOUT = '0;
        rd_active = 0;
        rd_cnt = 0;
        forever begin
            @(negedge clk_sys);
            s_acc_wr = bus.DDRAM_WE && !bus.DDRAM_BUSY;
            s_acc_rd = bus.DDRAM_RD && !bus.DDRAM_BUSY;
            s_a = bus.DDRAM_ADDR;
            s_d = bus.DDRAM_DIN;
            s_be = bus.DDRAM_BE;
            if ((bus.DDRAM_WE || bus.DDRAM_RD) && bus.DDRAM_BUSY && busy_hold > 0)
                busy_hold--;
            @(posedge clk_sys);
            #1;
            if (s_acc_wr) begin
                s_word = slave_read(s_a[21:0]);
                for (int k = 0; k < 8; k++)
                    if (s_be[k]) s_word[8*k +: 8] = s_d[8*k +: 8];
                mem64[s_a[21:0]] = s_word;
            end
            bus.DDRAM_DOUT_READY = 1'b0;
            if (rd_active) begin
                if (rd_cnt == 0) begin
                    bus.DDRAM_DOUT_READY = 1'b1;
                    bus.DDRAM_DOUT = slave_read(rd_w);
                    rd_active = 0;
                end else begin
                    rd_cnt--;
                end
            end
            if (s_acc_rd) begin
                check("rd_overlap", 64'(rd_active), 64'd0);
                rd_active = 1;
                rd_w = s_a[21:0];
                rd_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 6));
                rd_accepts++;
            end
            if (busy_hold > 0)
                bus.DDRAM_BUSY = 1'b1;
            else
                bus.DDRAM_BUSY = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Monitor: acks, read data, Avalon command contents
    logic    we_prev, rd_prev;
    bit      rst_prev = 1, wr_acc_prev = 0, dr_prev = 0;
    rd_exp_t m_e;
    initial begin
        forever begin
            @(negedge clk_sys);
            if (reset || rst_prev) begin
                we_prev = bus.we_ack;
                rd_prev = bus.rd_ack;
            end else begin
                if (bus.we_ack !== we_prev) begin
                    check("we_ack_expected", 64'(wr_ack_pending != 0), 64'd1);
                    if (wr_ack_pending != 0) wr_ack_pending--;
                    check("we_ack_timing", 64'(wr_acc_prev), 64'd1);
                end
                if (bus.rd_ack !== rd_prev) begin
                    check("rd_ack_expected", 64'(rd_q.size() != 0), 64'd1);
                    if (rd_q.size() != 0) begin
                        m_e = rd_q.pop_front();
                        check("dout", bus.dout, m_e.data);
                        if (m_e.miss) check("rd_ack_timing", 64'(dr_prev), 64'd1);
                    end
                end
                we_prev = bus.we_ack;
                rd_prev = bus.rd_ack;
            end
            if (bus.DDRAM_WE || bus.DDRAM_RD)
                check("rd_we_exclusive", 64'(bus.DDRAM_WE && bus.DDRAM_RD), 64'd0);
            if (bus.DDRAM_WE) begin
                check("wr_cmd_expected", 64'(wcmd_q.size() != 0), 64'd1);
                if (wcmd_q.size() != 0) begin
                    check("wr_addr", 64'(bus.DDRAM_ADDR), 64'(wcmd_q[0].addr));
                    check("wr_din", bus.DDRAM_DIN, wcmd_q[0].din);
                    check("wr_be", 64'(bus.DDRAM_BE), 64'(wcmd_q[0].be));
                    if (bus.DDRAM_BUSY) we_busy_cycles++;
                    else void'(wcmd_q.pop_front());
                end
            end
            if (bus.DDRAM_RD) begin
                check("rd_cmd_expected", 64'(rdcmd_q.size() != 0), 64'd1);
                if (rdcmd_q.size() != 0) begin
                    check("rd_addr", 64'(bus.DDRAM_ADDR), 64'(rdcmd_q[0]));
                    if (!bus.DDRAM_BUSY) void'(rdcmd_q.pop_front());
                end
            end
            wr_acc_prev = bus.DDRAM_WE && !bus.DDRAM_BUSY;
            dr_prev = bus.DDRAM_DOUT_READY;
            rst_prev = reset;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while ((bus.we_req != bus.we_ack || bus.rd_req != bus.rd_ack) && c < budget) begin
            tick();
            c++;
        end
        check(name, 64'(bus.we_req == bus.we_ack && bus.rd_req == bus.rd_ack), 64'd1);
    endtask

    task automatic model_write(input logic [24:0] a, input logic [15:0] d);
        wr_cmd_t c;
        ref_half[a[24:1]] = d;
        if (cache_v && cache_w == a[24:3]) cache_v = 0;
        c.addr = {BASE, a[24:3]};
        c.din  = {d, d, d, d};
        c.be   = 8'h03 << (2 * int'(a[2:1]));
        wcmd_q.push_back(c);
        wr_ack_pending++;
    endtask

    task automatic model_read(input logic [24:0] a, output bit miss);
        rd_exp_t e;
        miss = !(cache_v && cache_w == a[24:3]);
        if (miss) rdcmd_q.push_back({BASE, a[24:3]});
        e.data = ref_word(a[24:3]);
        e.miss = miss;
        rd_q.push_back(e);
        cache_v = 1;
        cache_w = a[24:3];
    endtask

    task automatic do_write(input logic [24:0] a, input logic [15:0] d);
        model_write(a, d);
        bus.wraddr = a;
        bus.din = d;
        bus.we_req = ~bus.we_req;
        wait_idle("wr_timeout", 200);
    endtask

    task automatic do_read(input logic [24:0] a);
        bit miss;
        model_read(a, miss);
        bus.rdaddr = a;
        bus.rd_req = ~bus.rd_req;
        if (!miss) begin
            tick();
            check("hit_latency", 64'(bus.rd_ack == bus.rd_req), 64'd1);
        end
        wait_idle("rd_timeout", 200);
    endtask

    task automatic do_both(input logic [24:0] wa, input logic [15:0] d, input logic [24:0] ra);
        bit miss;
        model_write(wa, d);
        model_read(ra, miss);
        bus.wraddr = wa;
        bus.din = d;
        bus.rdaddr = ra;
        bus.we_req = ~bus.we_req;
        bus.rd_req = ~bus.rd_req;
        wait_idle("both_timeout", 400);
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 25'($urandom_range(0, 31));
            2:       return 25'h1FFFFE0 + 25'($urandom_range(0, 31));
            default: return 25'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    int acc0;
    int op;
    logic [24:0] ra;
    initial begin
        reset = 1'b1;
        bus.we_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.wraddr = '0;
        bus.rdaddr = '0;
        bus.din = '0;
        tick(3);
        reset = 1'b0;
        tick();
        check("rst_rd", 64'(bus.DDRAM_RD), 64'd0);
        check("rst_we", 64'(bus.DDRAM_WE), 64'd0);
        check("rst_dout", bus.dout, 64'd0);
        check("rst_we_ack", 64'(bus.we_ack), 64'(bus.we_req));
        check("rst_rd_ack", 64'(bus.rd_ack), 64'(bus.rd_req));
        check("burstcnt", 64'(bus.DDRAM_BURSTCNT), 64'd1);

        busy_hold = 5;
        we_busy_cycles = 0;
        do_write(25'h000006, 16'hA55A);
        check("busy_hold_cycles", 64'(we_busy_cycles), 64'd5);
        check("wr6_addr", 64'(bus.DDRAM_ADDR), 64'({7'h18, 22'h0}));
        check("wr6_be", 64'(bus.DDRAM_BE), 64'hC0);
        check("wr6_din", bus.DDRAM_DIN, 64'hA55A_A55A_A55A_A55A);

        preload(22'h2, 64'h0123_4567_89AB_CDEF);
        lat_fixed = 7;
        do_read(25'h000010);
        check("miss_dout", bus.dout, 64'h0123_4567_89AB_CDEF);
        check("miss_addr", 64'(bus.DDRAM_ADDR), 64'({7'h18, 22'h2}));
        acc0 = rd_accepts;
        do_read(25'h000014);
        check("hit_no_rd", 64'(rd_accepts), 64'(acc0));
        check("hit_dout", bus.dout, 64'h0123_4567_89AB_CDEF);

        do_write(25'h000012, 16'hBEEF);
        acc0 = rd_accepts;
        do_read(25'h000010);
        check("inval_rd_issued", 64'(rd_accepts), 64'(acc0 + 1));
        check("inval_dout", bus.dout, 64'h0123_4567_BEEF_CDEF);

        do_both(25'h000016, 16'h1234, 25'h000010);
        check("both_dout", bus.dout, 64'h1234_4567_BEEF_CDEF);
        tick();
        check("both_acks_once", 64'(wr_ack_pending + rd_q.size()), 64'd0);

        lat_fixed = -1;
        do_write(25'h1FFFFFF, 16'hC3C3);
        check("top_addr", 64'(bus.DDRAM_ADDR), 64'({7'h18, 22'h3FFFFF}));
        check("top_be", 64'(bus.DDRAM_BE), 64'hC0);
        do_read(25'h1FFFFF8);

        // reset while a read is in flight
        lat_fixed = 5;
        acc0 = rd_accepts;
        begin
            bit miss;
            model_read(25'h000040, miss);
        end
        bus.rdaddr = 25'h000040;
        bus.rd_req = ~bus.rd_req;
        for (int i = 0; i < 50 && rd_accepts == acc0; i++) tick();
        check("rdwait_reached", 64'(rd_accepts != acc0), 64'd1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rd_q.delete();
        cache_v = 0;
        check("post_rst_we_ack", 64'(bus.we_ack), 64'(bus.we_req));
        check("post_rst_rd_ack", 64'(bus.rd_ack), 64'(bus.rd_req));
        lat_fixed = 2;
        do_read(25'h000080);
        check("post_rst_dout", bus.dout, ref_word(22'h10));
        lat_fixed = -1;

        rand_busy = 1;
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            ra = rand_addr();
            if (op < 4) do_write(ra, 16'($urandom));
            else if (op < 8) do_read(ra);
            else do_both(rand_addr(), 16'($urandom), ra);
        end

        tick(3);
        check("end_rd_q", 64'(rd_q.size()), 64'd0);
        check("end_wcmd_q", 64'(wcmd_q.size()), 64'd0);
        check("end_rdcmd_q", 64'(rdcmd_q.size()), 64'd0);
        check("end_wr_acks", 64'(wr_ack_pending), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
